// File: rtl/dht11_sample_sched.sv
// DHT11 acquisition scheduler: periodic/forced start requests, per-transaction timeout,
// bounded retries with a guard gap, good-reading latch and stale-data flag.
module dht11_sample_sched #(
  parameter int unsigned SAMPLE_PERIOD = 60_000_000,
  parameter int unsigned TIMEOUT       = 2_500_000,
  parameter int unsigned RETRY_GAP     = 50_000_000,
  parameter int unsigned MAX_RETRY     = 3,
  parameter int unsigned STALE_LIMIT   = 3
) (
  input  logic        clk_50m,
  input  logic        rst_n,
  input  logic        en,
  input  logic        force_req,
  output logic        drv_start,
  input  logic        drv_busy,
  input  logic        drv_done,
  input  logic        drv_ok,
  input  logic [15:0] drv_temp,
  input  logic [15:0] drv_humi,
  output logic [15:0] temp,
  output logic [15:0] humi,
  output logic        data_valid,
  output logic        stale,
  output logic        upd_stb,
  output logic [7:0]  err_cnt
);

  localparam int unsigned M1   = (SAMPLE_PERIOD > TIMEOUT) ? SAMPLE_PERIOD : TIMEOUT;
  localparam int unsigned CMAX = (M1 > RETRY_GAP) ? M1 : RETRY_GAP;
  localparam int unsigned CW   = $clog2(CMAX + 1);
  localparam int unsigned AW   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int unsigned SW   = $clog2(STALE_LIMIT + 1);

  localparam logic [CW-1:0] PER_LAST = CW'(SAMPLE_PERIOD - 1);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(RETRY_GAP - 1);
  localparam logic [AW-1:0] ATT_MAX  = AW'(MAX_RETRY);
  localparam logic [SW-1:0] STK_MAX  = SW'(STALE_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_PERIOD,
    S_START,
    S_WAIT_DONE,
    S_GAP,
    S_UPDATE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] attempt_q, attempt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [7:0]    err_q, err_d;
  logic          stale_q, stale_d;
  logic          valid_q, valid_d;
  logic [15:0]   temp_q, temp_d;
  logic [15:0]   humi_q, humi_d;
  logic          fail;

  // One counter serves the period, timeout and gap phases; each phase clears it on entry.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    attempt_d = attempt_q;
    streak_d  = streak_q;
    err_d     = err_q;
    stale_d   = stale_q;
    valid_d   = valid_q;
    temp_d    = temp_q;
    humi_d    = humi_q;
    drv_start = 1'b0;
    upd_stb   = 1'b0;
    fail      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (en) begin
          state_d   = S_WAIT_PERIOD;
          cnt_d     = '0;
          attempt_d = '0;
        end
      end
      S_WAIT_PERIOD: begin
        cnt_d = cnt_q + 1'b1;
        if (!en)                                 state_d = S_IDLE;
        else if ((cnt_q == PER_LAST) || force_req) state_d = S_START;
      end
      S_START: begin
        if (!drv_busy) begin
          drv_start = 1'b1;
          cnt_d     = '0;
          state_d   = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        cnt_d = cnt_q + 1'b1;
        if (drv_done) begin
          if (drv_ok) begin
            temp_d    = drv_temp;
            humi_d    = drv_humi;
            valid_d   = 1'b1;
            stale_d   = 1'b0;
            streak_d  = '0;
            attempt_d = '0;
            state_d   = S_UPDATE;
          end else begin
            fail = 1'b1;
          end
        end else if (cnt_q == TO_LAST) begin
          fail = 1'b1;
        end
      end
      S_GAP: begin
        cnt_d = cnt_q + 1'b1;
        if (!en)                    state_d = S_IDLE;
        else if (cnt_q == GAP_LAST) state_d = S_START;
      end
      S_UPDATE: begin
        upd_stb = 1'b1;
        cnt_d   = '0;
        state_d = en ? S_WAIT_PERIOD : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (fail) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      cnt_d = '0;
      if (attempt_q < ATT_MAX) begin
        attempt_d = attempt_q + 1'b1;
        state_d   = S_GAP;
      end else begin
        if (streak_q != STK_MAX) streak_d = streak_q + 1'b1;
        if (streak_d == STK_MAX) stale_d = 1'b1;
        attempt_d = '0;
        state_d   = en ? S_WAIT_PERIOD : S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_50m or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      attempt_q <= '0;
      streak_q  <= '0;
      err_q     <= '0;
      stale_q   <= 1'b0;
      valid_q   <= 1'b0;
      temp_q    <= '0;
      humi_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      attempt_q <= attempt_d;
      streak_q  <= streak_d;
      err_q     <= err_d;
      stale_q   <= stale_d;
      valid_q   <= valid_d;
      temp_q    <= temp_d;
      humi_q    <= humi_d;
    end
  end

  assign temp       = temp_q;
  assign humi       = humi_q;
  assign data_valid = valid_q;
  assign stale      = stale_q;
  assign err_cnt    = err_q;

endmodule

// File: tb/tb_dht11_sample_sched.sv
// Bench for dht11_sample_sched: per-period scenario table plus hand sequences for
// force_req, busy hold, disable and reset corners; readings checked via a scoreboard queue.
`timescale 1ns/1ps
module tb_dht11_sample_sched;
  localparam int SP = 100, TO = 20, RG = 10, MR = 2, SL = 2;
  localparam logic [1:0] K_SIL = 2'd0, K_BAD = 2'd1, K_GOOD = 2'd2;

  logic        clk_50m = 1'b0, rst_n = 1'b0, en = 1'b0, force_req = 1'b0;
  logic        drv_busy = 1'b0, drv_done = 1'b0, drv_ok = 1'b0;
  logic [15:0] drv_temp = '0, drv_humi = '0;
  logic        drv_start, data_valid, stale, upd_stb;
  logic [15:0] temp, humi;
  logic [7:0]  err_cnt;

  int n_tests = 0, n_fail = 0, cyc = 0, n_starts = 0, exp_next = -1;
  logic [15:0] last_t = '0, last_h = '0;

  typedef struct packed { logic [15:0] t; logic [15:0] h; } rd_t;
  rd_t sb_q[$];
  rd_t exp_rd;

  typedef struct {
    logic [1:0]  k0, k1, k2;
    int          d;
    logic [15:0] t, h;
    logic [7:0]  err;
    logic        st;
    logic        val;
  } vec_t;
  vec_t vecs[8];

  dht11_sample_sched #(
    .SAMPLE_PERIOD(SP), .TIMEOUT(TO), .RETRY_GAP(RG), .MAX_RETRY(MR), .STALE_LIMIT(SL)
  ) dut (
    .clk_50m(clk_50m), .rst_n(rst_n), .en(en), .force_req(force_req),
    .drv_start(drv_start), .drv_busy(drv_busy), .drv_done(drv_done), .drv_ok(drv_ok),
    .drv_temp(drv_temp), .drv_humi(drv_humi), .temp(temp), .humi(humi),
    .data_valid(data_valid), .stale(stale), .upd_stb(upd_stb), .err_cnt(err_cnt)
  );

  always #10 clk_50m = ~clk_50m;
  always @(posedge clk_50m) cyc <= cyc + 1;
  always @(negedge clk_50m) if (drv_start === 1'b1) n_starts++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected to finish", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk_50m) begin
    if (rst_n === 1'b1 && upd_stb === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL upd_unexpected: upd_stb=1 with no pending reading, expected 0 (cycle %0d)", cyc);
      end else begin
        exp_rd = sb_q.pop_front();
        check("sb_temp", 32'(temp), 32'(exp_rd.t));
        check("sb_humi", 32'(humi), 32'(exp_rd.h));
        check("sb_valid", 32'(data_valid), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk_50m);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  // Returns with t = cycle of the drv_start pulse, positioned just after the edge starting cycle t+2.
  task automatic wait_start(input int limit, output int t);
    t = -1;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk_50m);
      if (drv_start === 1'b1) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL start_timeout: no drv_start within %0d cycles, expected one", limit);
    end
    tick();
    @(negedge clk_50m);
    check("start_single_cycle", 32'(drv_start), 32'd0);
    tick();
  endtask

  // Plays the driver for the transaction started at cycle s; returns at the negedge of tend+1.
  task automatic respond(input logic [1:0] kind, input int d, input int s,
                         input logic [15:0] t, input logic [15:0] h, output int tend);
    if (kind == K_SIL) begin
      goto(s + TO + 1);
      tend = s + TO;
      @(negedge clk_50m);
      check("upd_on_silent", 32'(upd_stb), 32'd0);
    end else begin
      goto(s + d);
      drv_done = 1'b1;
      drv_ok   = (kind == K_GOOD);
      drv_temp = t;
      drv_humi = h;
      if (kind == K_GOOD) sb_q.push_back('{t: t, h: h});
      tick();
      drv_done = 1'b0;
      drv_ok   = 1'b0;
      drv_temp = 16'($urandom);
      drv_humi = 16'($urandom);
      tend = s + d;
      @(negedge clk_50m);
      check("upd_latency", 32'(upd_stb), (kind == K_GOOD) ? 32'd1 : 32'd0);
    end
  endtask

  function automatic logic [1:0] kind_of(input vec_t v, input int a);
    return (a == 0) ? v.k0 : (a == 1) ? v.k1 : v.k2;
  endfunction

  task automatic run_vec(input vec_t v);
    int ts, tend, tprev;
    logic [1:0] k;
    tend = 0;
    k = K_SIL;
    for (int a = 0; a <= MR; a++) begin
      k = kind_of(v, a);
      wait_start(400, ts);
      if (a == 0) check("period_start", 32'(ts), 32'(exp_next));
      else        check("retry_spacing", 32'(ts - tprev), 32'd11);
      respond(k, v.d, ts, v.t, v.h, tend);
      tprev = tend;
      if (k == K_GOOD) begin
        last_t = v.t;
        last_h = v.h;
        break;
      end
    end
    exp_next = (k == K_GOOD) ? tend + 102 : tend + 101;
    check("err_cnt", 32'(err_cnt), 32'(v.err));
    check("stale", 32'(stale), 32'(v.st));
    check("data_valid", 32'(data_valid), 32'(v.val));
    check("temp_hold", 32'(temp), 32'(last_t));
    check("humi_hold", 32'(humi), 32'(last_h));
  endtask

  initial begin
    int ts, tend, e, n0, c;
    vecs[0] = '{K_GOOD, K_SIL,  K_SIL,  10, 16'h1A05, 16'h3700, 8'd0,  1'b0, 1'b1};
    vecs[1] = '{K_SIL,  K_SIL,  K_SIL,  0,  16'h0000, 16'h0000, 8'd3,  1'b0, 1'b1};
    vecs[2] = '{K_SIL,  K_SIL,  K_SIL,  0,  16'h0000, 16'h0000, 8'd6,  1'b1, 1'b1};
    vecs[3] = '{K_BAD,  K_GOOD, K_SIL,  5,  16'h1B00, 16'h3800, 8'd7,  1'b0, 1'b1};
    vecs[4] = '{K_GOOD, K_SIL,  K_SIL,  TO, 16'h1C02, 16'h4001, 8'd7,  1'b0, 1'b1};
    vecs[5] = '{K_BAD,  K_BAD,  K_BAD,  3,  16'h0000, 16'h0000, 8'd10, 1'b0, 1'b1};
    vecs[6] = '{K_BAD,  K_SIL,  K_GOOD, 7,  16'h1D09, 16'h4502, 8'd12, 1'b0, 1'b1};
    vecs[7] = '{K_SIL,  K_SIL,  K_SIL,  0,  16'h0000, 16'h0000, 8'd15, 1'b0, 1'b1};

    repeat (3) tick();
    @(negedge clk_50m);
    check("rst_temp", 32'(temp), 32'd0);
    check("rst_humi", 32'(humi), 32'd0);
    check("rst_valid", 32'(data_valid), 32'd0);
    check("rst_stale", 32'(stale), 32'd0);
    check("rst_upd", 32'(upd_stb), 32'd0);
    check("rst_err", 32'(err_cnt), 32'd0);
    check("rst_start", 32'(drv_start), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    en = 1'b1;
    exp_next = cyc + SP + 1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // force_req at period count 40, then ignored during WAIT_DONE and GAP
    e = exp_next - SP;
    goto(e + 40);
    force_req = 1'b1; tick(); force_req = 1'b0;
    wait_start(60, ts);
    check("force40_start", 32'(ts), 32'(e + 41));
    force_req = 1'b1; tick(); force_req = 1'b0;
    respond(K_BAD, 5, ts, 16'h0, 16'h0, tend);
    goto(ts + 9);
    force_req = 1'b1; tick(); force_req = 1'b0;
    wait_start(60, ts);
    check("force_gap_ignored", 32'(ts), 32'(tend + 11));
    respond(K_GOOD, 4, ts, 16'h1E01, 16'h3F00, tend);
    exp_next = tend + 102;
    check("force_err_cnt", 32'(err_cnt), 32'd16);

    // force_req coinciding with the period terminal count
    e = exp_next - SP;
    goto(e + 99);
    n0 = n_starts;
    force_req = 1'b1; tick(); force_req = 1'b0;
    wait_start(60, ts);
    check("force99_start", 32'(ts), 32'(e + 100));
    respond(K_GOOD, 10, ts, 16'h2305, 16'h4100, tend);
    check("force99_single", 32'(n_starts - n0), 32'd1);
    exp_next = tend + 102;

    // drv_busy holds the start request
    e = exp_next - SP;
    goto(e + 95);
    drv_busy = 1'b1;
    goto(e + 105);
    drv_busy = 1'b0;
    wait_start(60, ts);
    check("busy_delayed_start", 32'(ts), 32'(e + 105));
    respond(K_GOOD, 8, ts, 16'h2406, 16'h4202, tend);
    exp_next = tend + 102;

    // disable mid-transaction: completes, then stays idle
    wait_start(200, ts);
    check("period_start_dis", 32'(ts), 32'(exp_next));
    en = 1'b0;
    respond(K_GOOD, 6, ts, 16'h2207, 16'h5100, tend);
    n0 = n_starts;
    repeat (150) tick();
    check("no_start_disabled", 32'(n_starts - n0), 32'd0);
    check("temp_after_disable", 32'(temp), 32'h2207);
    check("err_after_disable", 32'(err_cnt), 32'd16);

    // asynchronous reset in the middle of WAIT_DONE
    en = 1'b1;
    c = cyc;
    wait_start(200, ts);
    check("reenable_start", 32'(ts), 32'(c + SP + 1));
    goto(ts + 3);
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    check("midrst_temp", 32'(temp), 32'd0);
    check("midrst_humi", 32'(humi), 32'd0);
    check("midrst_valid", 32'(data_valid), 32'd0);
    check("midrst_err", 32'(err_cnt), 32'd0);
    check("midrst_start", 32'(drv_start), 32'd0);
    goto(ts + 5);
    rst_n = 1'b1;
    goto(ts + 8);
    drv_done = 1'b1; drv_ok = 1'b1; drv_temp = 16'h3333; drv_humi = 16'h4444;
    tick();
    drv_done = 1'b0; drv_ok = 1'b0;
    @(negedge clk_50m);
    check("late_done_upd", 32'(upd_stb), 32'd0);
    check("late_done_temp", 32'(temp), 32'd0);
    tick();
    en = 1'b1;
    c = cyc;
    wait_start(200, ts);
    check("post_reset_start", 32'(ts), 32'(c + SP + 1));
    respond(K_GOOD, 10, ts, 16'h1905, 16'h2E00, tend);
    check("post_reset_valid", 32'(data_valid), 32'd1);
    check("post_reset_err", 32'(err_cnt), 32'd0);

    tick();
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
